// File: rtl/xor_descrambler_pkg.sv
// Shared constants for the x^7 + x^4 + 1 byte-wide scrambler/descrambler pair.
// Used by both the transmit-side scrambler and the receive-side descrambler.
package xor_descrambler_pkg;

    localparam int SCR_ORDER = 7;
    localparam int TAP_A     = 3;
    localparam int TAP_B     = 6;
    localparam int BYTE_W    = 8;
    localparam int CNT_W     = 16;

endpackage

// File: rtl/xor_descr_step.sv
// Combinational 8-bit unroll of the self-synchronizing descrambler history.
// Bit 0 of data_in is the earliest received bit and is processed first.
module xor_descr_step
    import xor_descrambler_pkg::*;
(
    input  logic [SCR_ORDER-1:0] s_in,
    input  logic [BYTE_W-1:0]    data_in,
    output logic [SCR_ORDER-1:0] s_out,
    output logic [BYTE_W-1:0]    data_out
);

    // s_chain[k] is the history seen by bit k; s_chain[BYTE_W] is the final state.
    logic [SCR_ORDER-1:0] s_chain [0:BYTE_W];

    assign s_chain[0] = s_in;

    generate
        for (genvar gi = 0; gi < BYTE_W; gi++) begin : g_bit
            assign data_out[gi]  = data_in[gi] ^ s_chain[gi][TAP_A] ^ s_chain[gi][TAP_B];
            assign s_chain[gi+1] = {s_chain[gi][SCR_ORDER-2:0], data_in[gi]};
        end
    endgenerate

    assign s_out = s_chain[BYTE_W];

endmodule

// File: rtl/xor_descrambler.sv
// Byte-wide x^7 + x^4 + 1 self-synchronizing descrambler with a one-deep output stage.
// Optional even-parity checking is enabled by defining XOR_DESCRAMBLER_PARITY_EN.
module xor_descrambler
    import xor_descrambler_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_sync,
    output logic [CNT_W-1:0]  byte_cnt
`ifdef XOR_DESCRAMBLER_PARITY_EN
    ,
    input  logic              in_parity,
    output logic              par_err,
    output logic [7:0]        par_err_cnt
`endif
);

    logic [SCR_ORDER-1:0] s_q, s_d;
    logic                 seen_q, seen_d;
    logic                 out_valid_q, out_valid_d;
    logic [BYTE_W-1:0]    out_data_q, out_data_d;
    logic                 out_sync_q, out_sync_d;
    logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;

    logic [SCR_ORDER-1:0] step_s;
    logic [BYTE_W-1:0]    step_data;
    logic                 accept;
    logic                 handoff;

    xor_descr_step u_step (
        .s_in     (s_q),
        .data_in  (in_data),
        .s_out    (step_s),
        .data_out (step_data)
    );

    // Flush blocks acceptance so the offered byte stays with the sender's view of "not taken".
    assign in_ready = (!out_valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign handoff  = out_valid_q && out_ready;

    always_comb begin
        s_d         = s_q;
        seen_d      = seen_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sync_d  = out_sync_q;
        byte_cnt_d  = byte_cnt_q;

        if (handoff) begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
        end

        if (flush) begin
            s_d         = '0;
            seen_d      = 1'b0;
            out_valid_d = 1'b0;
        end else if (accept) begin
            s_d         = step_s;
            seen_d      = 1'b1;
            out_valid_d = 1'b1;
            out_data_d  = step_data;
            out_sync_d  = seen_q;
        end else if (handoff) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q         <= '0;
            seen_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sync_q  <= 1'b0;
            byte_cnt_q  <= '0;
        end else begin
            s_q         <= s_d;
            seen_q      <= seen_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sync_q  <= out_sync_d;
            byte_cnt_q  <= byte_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sync  = out_sync_q;
    assign byte_cnt  = byte_cnt_q;

`ifdef XOR_DESCRAMBLER_PARITY_EN
    logic       par_err_q, par_err_d;
    logic [7:0] par_err_cnt_q, par_err_cnt_d;

    // Even parity: the XOR of data and parity bit must be zero for a clean byte.
    always_comb begin
        par_err_d     = par_err_q;
        par_err_cnt_d = par_err_cnt_q;
        if (!flush && accept) begin
            par_err_d = (^in_data) ^ in_parity;
        end
        if (handoff && par_err_q && (par_err_cnt_q != 8'hFF)) begin
            par_err_cnt_d = par_err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q     <= 1'b0;
            par_err_cnt_q <= 8'h00;
        end else begin
            par_err_q     <= par_err_d;
            par_err_cnt_q <= par_err_cnt_d;
        end
    end

    assign par_err     = par_err_q;
    assign par_err_cnt = par_err_cnt_q;
`endif

endmodule
